// File: rtl/bitty_uart_pkg.sv
// Shared opcodes, reply bytes and FSM encoding for the bitty UART memory protocol.
package bitty_uart_pkg;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_PING  = 8'h03;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_GET_ADDR = 4'd1,
    S_GET_DHI  = 4'd2,
    S_GET_DLO  = 4'd3,
    S_LOAD_TX  = 4'd4,
    S_WAIT_TX  = 4'd5,
    S_NEXT     = 4'd6
  } state_e;

  // Up to two error events can land in one cycle; the counter sticks at 0xFF.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/word_mem.sv
// DEPTH x 16 word store: one synchronous write port, one asynchronous read port.
module word_mem #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  logic [15:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_imem_responder.sv
// Host-side responder for the bitty UART memory protocol: decodes request bytes,
// serves 16-bit words from word_mem and sends reply bytes back through the UART.
module uart_imem_responder
  import bitty_uart_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              tx_done,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q;
  logic [7:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        dhi_q;
  logic [7:0]        lo_q;
  logic              second_q;
  logic              wr_pend_q;
  logic [15:0]       wr_data_q;
  logic [TW-1:0]     tcnt_q;

  logic              in_get;
  logic              timeout;
  logic              bad_op;
  logic              rx_busy;
  logic              prog_ok;
  logic              prog_rej;
  logic [1:0]        err_inc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;
  logic [15:0]       rd_data;

  assign busy = (state_q != S_IDLE);

  always_comb begin
    in_get   = (state_q == S_GET_ADDR) || (state_q == S_GET_DHI) || (state_q == S_GET_DLO);
    timeout  = in_get && !rx_done && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
    bad_op   = (state_q == S_IDLE) && rx_done &&
               !((rx_data == OP_READ) || (rx_data == OP_WRITE) || (rx_data == OP_PING));
    rx_busy  = rx_done &&
               ((state_q == S_LOAD_TX) || (state_q == S_WAIT_TX) || (state_q == S_NEXT));
    prog_ok  = prog_we && (state_q == S_IDLE) && !rx_done;
    prog_rej = prog_we && !prog_ok;
    // bad_op, timeout and rx_busy are state-exclusive, so at most one of them fires.
    err_inc  = {1'b0, bad_op | timeout | rx_busy} + {1'b0, prog_rej};
  end

  // The UART write lands only in LOAD_TX, where prog_we is always refused: no collision.
  always_comb begin
    mem_we    = wr_pend_q | prog_ok;
    mem_waddr = wr_pend_q ? addr_q : prog_addr;
    mem_wdata = wr_pend_q ? wr_data_q : prog_data;
  end

  word_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_word_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (rx_data[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= 8'h00;
      addr_q    <= '0;
      dhi_q     <= 8'h00;
      lo_q      <= 8'h00;
      second_q  <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_data_q <= 16'h0000;
      tcnt_q    <= '0;
      tx_en     <= 1'b0;
      tx_data   <= 8'h00;
      err_count <= 8'h00;
    end else begin
      tx_en     <= 1'b0;
      wr_pend_q <= 1'b0;
      err_count <= sat_add8(err_count, err_inc);

      if (in_get && !rx_done) begin
        tcnt_q <= tcnt_q + TW'(1);
      end else begin
        tcnt_q <= '0;
      end

      unique case (state_q)
        S_IDLE: begin
          if (rx_done) begin
            op_q <= rx_data;
            case (rx_data)
              OP_READ, OP_WRITE: state_q <= S_GET_ADDR;
              OP_PING: begin
                tx_data  <= ACK_BYTE;
                tx_en    <= 1'b1;
                second_q <= 1'b0;
                state_q  <= S_LOAD_TX;
              end
              default: begin
                tx_data  <= NAK_BYTE;
                tx_en    <= 1'b1;
                second_q <= 1'b0;
                state_q  <= S_LOAD_TX;
              end
            endcase
          end
        end
        S_GET_ADDR: begin
          if (rx_done) begin
            addr_q <= rx_data[ADDR_W-1:0];
            if (op_q == OP_READ) begin
              // Word is captured here, so later writes cannot disturb the reply.
              tx_data  <= rd_data[15:8];
              lo_q     <= rd_data[7:0];
              second_q <= 1'b1;
              tx_en    <= 1'b1;
              state_q  <= S_LOAD_TX;
            end else begin
              state_q <= S_GET_DHI;
            end
          end else if (timeout) begin
            state_q <= S_IDLE;
          end
        end
        S_GET_DHI: begin
          if (rx_done) begin
            dhi_q   <= rx_data;
            state_q <= S_GET_DLO;
          end else if (timeout) begin
            state_q <= S_IDLE;
          end
        end
        S_GET_DLO: begin
          if (rx_done) begin
            wr_data_q <= {dhi_q, rx_data};
            wr_pend_q <= 1'b1;
            tx_data   <= ACK_BYTE;
            tx_en     <= 1'b1;
            second_q  <= 1'b0;
            state_q   <= S_LOAD_TX;
          end else if (timeout) begin
            state_q <= S_IDLE;
          end
        end
        S_LOAD_TX: state_q <= S_WAIT_TX;
        S_WAIT_TX: begin
          if (tx_done) begin
            state_q <= second_q ? S_NEXT : S_IDLE;
          end
        end
        S_NEXT: begin
          tx_data  <= lo_q;
          tx_en    <= 1'b1;
          second_q <= 1'b0;
          state_q  <= S_LOAD_TX;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_imem_responder.sv
// Directed plus randomized bench for uart_imem_responder; acts as UART and host.
module tb_uart_imem_responder;

  localparam int unsigned TO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        tx_done;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic        busy;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  logic [15:0] model_mem [256];

  always #5 clk = ~clk;

  uart_imem_responder #(
    .ADDR_W         (8),
    .DEPTH          (256),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .tx_done   (tx_done),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .busy      (busy),
    .err_count (err_count)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_err(input string tag);
    int e;
    e = (exp_err > 255) ? 255 : exp_err;
    check(tag, 16'(err_count), 16'(e));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic prog_write(input logic [7:0] a, input logic [15:0] d);
    prog_addr = a;
    prog_data = d;
    prog_we   = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
    model_mem[a] = d;
  endtask

  // Entered in the cycle where tx_en must be high; acknowledges the byte as the UART.
  // pmode 2 fires a refused prog_we, inject fires a stray rx byte, both during WAIT_TX.
  task automatic tx_byte(input logic [7:0] exp, input string tag, input bit inject,
                         input bit pbusy);
    check({tag, "_tx_en"}, 16'(tx_en), 16'd1);
    check({tag, "_tx_data"}, 16'(tx_data), 16'(exp));
    @(negedge clk);
    if (inject) begin
      rx_data = 8'($urandom);
      rx_done = 1'b1;
      exp_err++;
    end
    if (pbusy) begin
      prog_addr = 8'h05;
      prog_data = 16'hDEAD;
      prog_we   = 1'b1;
      exp_err++;
    end
    @(negedge clk);
    rx_done = 1'b0;
    prog_we = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check({tag, "_hold"}, 16'(tx_data), 16'(exp));
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  // pmode: 0 none, 1 prog_we alongside the opcode byte, 2 prog_we while busy.
  task automatic request(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input int n, input logic [15:0] reply,
                         input int nrep, input string tag, input bit inject, input int pmode);
    logic [7:0] bs [4];
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    for (int i = 0; i < n; i++) begin
      if (i == 0 && pmode == 1) begin
        prog_addr = 8'h05;
        prog_data = 16'hBEEF;
        prog_we   = 1'b1;
        exp_err++;
      end
      send_byte(bs[i]);
      prog_we = 1'b0;
      if (i < n - 1) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    if (nrep == 2) begin
      tx_byte(reply[15:8], {tag, "_hi"}, inject, pmode == 2);
      check({tag, "_gap"}, 16'(tx_en), 16'd0);
      @(negedge clk);
      tx_byte(reply[7:0], {tag, "_lo"}, 1'b0, 1'b0);
    end else begin
      tx_byte(reply[7:0], tag, inject, pmode == 2);
    end
    check({tag, "_idle"}, 16'(busy), 16'd0);
  endtask

  task automatic do_read(input logic [7:0] a, input string tag, input bit inject, input int pm);
    request(8'h01, a, 8'h00, 8'h00, 2, model_mem[a], 2, tag, inject, pm);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d, input string tag);
    request(8'h02, a, d[15:8], d[7:0], 4, 16'h0006, 1, tag, 1'b0, 0);
    model_mem[a] = d;
  endtask

  initial begin
    logic saw_tx;
    logic [7:0] b;
    int kind;
    reset = 1'b0; rx_done = 1'b0; rx_data = 8'h00; tx_done = 1'b0;
    prog_we = 1'b0; prog_addr = 8'h00; prog_data = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_tx_en", 16'(tx_en), 16'd0);
    check("rst_tx_data", 16'(tx_data), 16'd0);
    check("rst_err", 16'(err_count), 16'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 256; a++) prog_write(8'(a), 16'($urandom));
    prog_write(8'h05, 16'hA1B2);
    do_read(8'h05, "read05", 1'b0, 0);

    do_write(8'h10, 16'h1234, "write10");
    do_read(8'h10, "read10", 1'b0, 0);
    do_write(8'hFF, 16'($urandom), "writeFF");
    do_read(8'hFF, "readFF", 1'b0, 0);
    check_err("err_clean");

    request(8'h7E, 8'h00, 8'h00, 8'h00, 1, 16'h0015, 1, "nak", 1'b0, 0);
    exp_err++;
    check_err("err_nak");

    // Stalled READ: abandoned after TO idle clocks with no reply.
    send_byte(8'h01);
    check("to_busy_start", 16'(busy), 16'd1);
    saw_tx = tx_en;
    repeat (TO - 1) begin
      @(negedge clk);
      saw_tx |= tx_en;
    end
    check("to_busy_last", 16'(busy), 16'd1);
    @(negedge clk);
    saw_tx |= tx_en;
    exp_err++;
    check("to_idle", 16'(busy), 16'd0);
    check("to_no_tx", 16'(saw_tx), 16'd0);
    check_err("err_timeout");
    request(8'h03, 8'h00, 8'h00, 8'h00, 1, 16'h0006, 1, "ping_after_to", 1'b0, 0);

    do_read(8'h10, "read_inject", 1'b1, 0);
    check_err("err_inject");
    do_read(8'h10, "read_pbusy", 1'b0, 2);
    check_err("err_pbusy");
    request(8'h03, 8'h00, 8'h00, 8'h00, 1, 16'h0006, 1, "ping_prog", 1'b0, 1);
    check_err("err_pcoll");
    do_read(8'h05, "read05_kept", 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      b = 8'($urandom);
      case (kind)
        0, 1: do_read(b, "rnd_read", 1'b0, 0);
        2: do_write(b, 16'($urandom), "rnd_write");
        3: request(8'h03, 8'h00, 8'h00, 8'h00, 1, 16'h0006, 1, "rnd_ping", 1'b0, 0);
        4: begin
          if (b >= 8'h01 && b <= 8'h03) b = 8'h80;
          request(b, 8'h00, 8'h00, 8'h00, 1, 16'h0015, 1, "rnd_nak", 1'b0, 0);
          exp_err++;
        end
        default: prog_write(b, 16'($urandom));
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check_err("err_random");

    // Reset while the first READ reply byte is in flight.
    send_byte(8'h01);
    send_byte(8'h10);
    check("rr_tx_en", 16'(tx_en), 16'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rr_tx_en_low", 16'(tx_en), 16'd0);
    check("rr_busy", 16'(busy), 16'd0);
    check("rr_err", 16'(err_count), 16'd0);
    exp_err = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    request(8'h03, 8'h00, 8'h00, 8'h00, 1, 16'h0006, 1, "ping_after_rst", 1'b0, 0);
    do_read(8'h10, "read_after_rst", 1'b0, 0);
    check_err("err_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_imem_responder.md
Name: uart_imem_responder

Overview:
- Host-side responder for the bitty UART memory protocol: the other end of the core's instruction-fetch and load/store requests.
- Receives request bytes from a uart_module receiver.
- Serves 16-bit words from an internal word memory and returns reply bytes through the same uart_module transmitter.
- Sits in the FPGA test harness / memory-emulator top; also preloadable through a direct program port.

Parameters:
- ADDR_W, 8, word address width (matches bitty PC width).
- DEPTH, 256, number of 16-bit words; must be 2**ADDR_W.
- TIMEOUT_CYCLES, 65535, idle clocks after which a partial request is abandoned.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rx_done  in  1  one-cycle pulse: rx_data holds a new byte.
- rx_data  in  8  received byte.
- tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
- tx_en  out  1  one-cycle start pulse to transmitter.
- tx_data  out  8  byte to send; held stable from tx_en until tx_done.
- prog_we  in  1  direct memory write strobe.
- prog_addr  in  ADDR_W  direct write address.
- prog_data  in  16  direct write data.
- busy  out  1  high in any state other than IDLE.
- err_count  out  8  saturating count of protocol errors.

Behaviour:
- Reset (asynchronous): state=IDLE; tx_en=0, tx_data=0, busy=0, err_count=0; timeout counter=0. Memory contents are not reset.
- Protocol, big-endian, half-duplex. Reply bytes: ACK=0x06, NAK=0x15.
  - 0x01 READ, addr: reply mem[addr][15:8], then mem[addr][7:0].
  - 0x02 WRITE, addr, d_hi, d_lo: write mem[addr]={d_hi,d_lo} in the cycle after d_lo is received; then reply ACK.
  - 0x03 PING: reply ACK.
  - Any other opcode: reply NAK; err_count+1.
- States:
  - IDLE: wait for an opcode.
  - GET_ADDR, GET_DHI, GET_DLO: collect operand bytes.
  - LOAD_TX: drive tx_data and pulse tx_en.
  - WAIT_TX: wait for tx_done.
  - NEXT: after tx_done, either queue the low byte or return to IDLE.
- Latency: rx_done for the last request byte in cycle N -> tx_en=1 in cycle N+1 with tx_data valid. After the first reply byte's tx_done in cycle M -> second tx_en in cycle M+2. Back to IDLE the cycle after the final tx_done.
- READ data is sampled from memory when the addr byte arrives; it is not affected by later writes.
- Timeout: counter clears on every rx_done. In GET_* states, TIMEOUT_CYCLES clocks without rx_done -> IDLE, no reply, err_count+1.
- rx_done during LOAD_TX, WAIT_TX or NEXT: byte discarded, err_count+1, state unchanged.
- prog_we:
  - Accepted only when state==IDLE and no rx_done in the same cycle; otherwise ignored and err_count+1.
  - When accepted, writes in the same cycle.
- err_count saturates at 0xFF.
- Address wraps naturally within ADDR_W bits; no out-of-range case.
- Reset mid-transfer: immediate IDLE, tx_en drops. A byte already in the UART completes without responder involvement.

Decomposition:
- Shared package bitty_uart_pkg holds:
  - opcode constants OP_READ=0x01, OP_WRITE=0x02, OP_PING=0x03;
  - ACK/NAK byte constants;
  - state encoding localparams (4-bit, S_ prefix).
- Sub-module word_mem: DEPTH x 16 array with one synchronous write port and one asynchronous read port. The responder arbitrates its two write sources (UART WRITE, prog_we) into that single port.

Test Plan:
- Preload via prog_we: addr 0x05=0xA1B2. Send 0x01,0x05 -> tx bytes 0xA1 then 0xB2. First tx_en exactly one cycle after the address rx_done.
- Send 0x02,0x10,0x12,0x34 -> ACK 0x06. Then 0x01,0x10 -> 0x12,0x34. Also read 0xFF after writing it (top address).
- Send opcode 0x7E -> single NAK 0x15; err_count=1; busy returns to 0.
- Send 0x01, then stall TIMEOUT_CYCLES (bench override TIMEOUT_CYCLES=100) -> IDLE, no tx_en, err_count+1. A following 0x03 -> ACK.
- Inject rx_done while WAIT_TX -> byte ignored, reply sequence unchanged, err_count+1. prog_we while busy -> memory unchanged.
- Assert reset during WAIT_TX of a READ -> tx_en=0, busy=0, err_count=0 immediately. Next PING answered normally.
